// File: rtl/sort_pkg.sv
// Shared constants and slot state for the sorted frame serializer.
package sort_pkg;

    localparam int unsigned LANES = 4;
    localparam int unsigned IDX_W = 2;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/sorted_frame_serializer_if.sv
// Parallel frame input and serial element output of the sorted frame serializer.
interface sorted_frame_serializer_if #(
    parameter int unsigned N = 8
);

    logic                in_valid;
    logic                in_ready;
    logic signed [N-1:0] i1;
    logic signed [N-1:0] i2;
    logic signed [N-1:0] i3;
    logic signed [N-1:0] i4;
    logic                out_valid;
    logic                out_ready;
    logic signed [N-1:0] out_data;
    logic [1:0]          out_idx;
    logic                out_last;

    modport master (
        output in_valid, i1, i2, i3, i4, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last
    );

    modport slave (
        input  in_valid, i1, i2, i3, i4, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last
    );

endinterface

// File: rtl/sort_frame_slot.sv
// One ping-pong buffer slot: a 4-lane frame register with its FULL flag.
module sort_frame_slot
    import sort_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load_i,
    input  logic                      free_i,
    input  logic [LANES-1:0][N-1:0]   data_i,
    output logic [LANES-1:0][N-1:0]   data_o,
    output logic                      full_o
);

    slot_state_e               state_d, state_q;
    logic [LANES-1:0][N-1:0]   data_d, data_q;

    // Load only hits an EMPTY slot and free only a FULL one, so they never coincide.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (load_i) begin
            state_d = SLOT_FULL;
            data_d  = data_i;
        end else if (free_i) begin
            state_d = SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign data_o = data_q;
    assign full_o = (state_q == SLOT_FULL);

endmodule

// File: rtl/sorted_frame_serializer.sv
// Two-slot ping-pong serializer emitting 4-element frames smallest first.
// Optional order checker enabled by defining SORTED_FRAME_CHECK_EN.
module sorted_frame_serializer
    import sort_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    sorted_frame_serializer_if.slave  bus,
    output logic                      busy,
    output logic                      sort_err
);

    typedef logic [LANES-1:0][N-1:0] frame_t;

    logic             wr_ptr_d, wr_ptr_q;
    logic             rd_ptr_d, rd_ptr_q;
    logic [IDX_W-1:0] idx_d, idx_q;
    logic [1:0]       slot_full;
    frame_t           slot_data [2];
    frame_t           in_frame;
    logic             accept, beat, final_beat;

    assign in_frame   = {bus.i4, bus.i3, bus.i2, bus.i1};
    assign accept     = bus.in_valid && bus.in_ready;
    assign beat       = bus.out_valid && bus.out_ready;
    assign final_beat = beat && (idx_q == IDX_W'(LANES - 1));

    for (genvar g = 0; g < 2; g++) begin : g_slot
        sort_frame_slot #(
            .N (N)
        ) u_slot (
            .clk    (clk),
            .rst    (rst),
            .load_i (accept && (wr_ptr_q == 1'(g))),
            .free_i (final_beat && (rd_ptr_q == 1'(g))),
            .data_i (in_frame),
            .data_o (slot_data[g]),
            .full_o (slot_full[g])
        );
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        idx_d    = idx_q;
        if (accept) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (final_beat) begin
            rd_ptr_d = ~rd_ptr_q;
            idx_d    = '0;
        end else if (beat) begin
            idx_d    = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            idx_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            idx_q    <= idx_d;
        end
    end

    // A slot freed this cycle only shows up in in_ready once its flag has cleared.
    assign bus.in_ready  = !rst && !slot_full[wr_ptr_q];
    assign bus.out_valid = slot_full[rd_ptr_q];
    assign bus.out_data  = bus.out_valid ? $signed(slot_data[rd_ptr_q][idx_q]) : '0;
    assign bus.out_idx   = idx_q;
    assign bus.out_last  = bus.out_valid && (idx_q == IDX_W'(LANES - 1));
    assign busy          = |slot_full;

`ifdef SORTED_FRAME_CHECK_EN
    logic err_d, err_q;

    always_comb begin
        err_d = err_q;
        if (accept && !((bus.i1 <= bus.i2) && (bus.i2 <= bus.i3) && (bus.i3 <= bus.i4))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign sort_err = err_q;
`else
    assign sort_err = 1'b0;
`endif

endmodule

// File: tb/tb_sorted_frame_serializer.sv
// Randomized bench for sorted_frame_serializer against a frame-queue reference model.
module tb_sorted_frame_serializer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    logic sort_err;

    sorted_frame_serializer_if #(.N(8)) bus ();

    sorted_frame_serializer #(
        .N (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .busy     (busy),
        .sort_err (sort_err)
    );

    always #5 clk = ~clk;

`ifdef SORTED_FRAME_CHECK_EN
    localparam bit ExpErr = 1'b1;
`else
    localparam bit ExpErr = 1'b0;
`endif

    typedef logic signed [7:0] frm_t [4];

    int   n_cmp = 0;
    int   n_err = 0;
    bit   check_en = 1'b0;
    frm_t mq [$];
    int   mk = 0;
    bit   merr = 1'b0;

    task automatic chk(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO of at most two frames and a beat index into the head frame.
    always @(negedge clk) begin
        frm_t f;
        bit   acc;
        if (check_en) begin
            chk("in_ready", bus.in_ready, (!rst && mq.size() < 2));
            chk("out_valid", bus.out_valid, (mq.size() > 0));
            chk("busy", busy, (mq.size() > 0));
            chk("sort_err", sort_err, merr);
            if (mq.size() > 0) begin
                chk("out_data", bus.out_data, mq[0][mk]);
                chk("out_idx", bus.out_idx, mk);
                chk("out_last", bus.out_last, (mk == 3));
            end else begin
                chk("out_last_idle", bus.out_last, 0);
            end
        end
        if (rst) begin
            mq.delete();
            mk   = 0;
            merr = 1'b0;
        end else begin
            acc = bus.in_valid && (mq.size() < 2);
            if (mq.size() > 0 && bus.out_ready) begin
                mk++;
                if (mk == 4) begin
                    void'(mq.pop_front());
                    mk = 0;
                end
            end
            if (acc) begin
                f[0] = bus.i1;
                f[1] = bus.i2;
                f[2] = bus.i3;
                f[3] = bus.i4;
                mq.push_back(f);
                if (ExpErr && !(f[0] <= f[1] && f[1] <= f[2] && f[2] <= f[3])) merr = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int a, input int b, input int c, input int d, output int waited);
        bit ok;
        ok     = 1'b0;
        waited = -1;
        bus.in_valid = 1'b1;
        bus.i1 = 8'(a);
        bus.i2 = 8'(b);
        bus.i3 = 8'(c);
        bus.i4 = 8'(d);
        for (int n = 0; n < 64 && !ok; n++) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
            if (ok) waited = n;
        end
        bus.in_valid = 1'b0;
        chk("send_accept", ok, 1);
    endtask

    // Called in the cycle after accept with out_ready high; checks four literal beats.
    task automatic expect_frame(input string name, input int a, input int b, input int c,
                                input int d);
        int e [4];
        e[0] = a; e[1] = b; e[2] = c; e[3] = d;
        for (int j = 0; j < 4; j++) begin
            chk({name, "_data"}, bus.out_data, e[j]);
            chk({name, "_idx"}, bus.out_idx, j);
            chk({name, "_last"}, bus.out_last, (j == 3));
            step();
        end
    endtask

    initial begin
        int w;
        int v [4];
        int t;
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int w;
        int v [4];
        int t;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.i1 = '0; bus.i2 = '0; bus.i3 = '0; bus.i4 = '0;
        step();
        step();
        check_en = 1'b1;
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_idx", bus.out_idx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sort_err", sort_err, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", bus.in_ready, 1);
        step();

        // Single frame, out_ready held high.
        bus.out_ready = 1'b1;
        send(-3, 0, 5, 7, w);
        expect_frame("single", -3, 0, 5, 7);
        chk("single_busy_after", busy, 0);

        // Boundary values.
        send(-128, -128, 127, 127, w);
        expect_frame("bound", -128, -128, 127, 127);
        chk("bound_sort_err", sort_err, 0);

        // Backpressure: out_ready toggles every cycle.
        bus.out_ready = 1'b0;
        send(1, 2, 3, 4, w);
        for (int n = 0; n < 12; n++) begin
            bus.out_ready = ~bus.out_ready;
            step();
        end
        bus.out_ready = 1'b1;
        step();
        chk("bp_drained", busy, 0);

        // Full buffer: two frames fill both slots, the third waits for a free slot.
        bus.out_ready = 1'b0;
        send(10, 11, 12, 13, w);
        send(20, 21, 22, 23, w);
        bus.in_valid = 1'b1;
        chk("full_in_ready", bus.in_ready, 0);
        step();
        step();
        chk("full_in_ready_held", bus.in_ready, 0);
        chk("full_head_data", bus.out_data, 10);
        bus.out_ready = 1'b1;
        send(30, 31, 32, 33, w);
        chk("full_f3_wait", w, 4);
        for (int n = 0; n < 12; n++) step();
        chk("full_drained", busy, 0);

        // Order check.
        send(4, 2, 9, 10, w);
        chk("order_sort_err", sort_err, ExpErr);
        expect_frame("order", 4, 2, 9, 10);
        chk("order_sticky", sort_err, ExpErr);

        // Reset after the second beat.
        send(50, 60, 70, 80, w);
        step();
        step();
        chk("mid_idx_before_rst", bus.out_idx, 2);
        rst = 1'b1;
        step();
        chk("mid_out_valid", bus.out_valid, 0);
        chk("mid_out_idx", bus.out_idx, 0);
        chk("mid_busy", busy, 0);
        chk("mid_sort_err", sort_err, 0);
        chk("mid_in_ready", bus.in_ready, 0);
        rst = 1'b0;
        step();
        send(-1, 0, 1, 2, w);
        expect_frame("after_rst", -1, 0, 1, 2);

        // Randomized traffic, mostly sorted frames, rare resets.
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < 4; i++) v[i] = int'($urandom_range(0, 255)) - 128;
            if ($urandom_range(0, 9) != 0) begin
                for (int i = 0; i < 3; i++) begin
                    for (int j = 0; j < 3 - i; j++) begin
                        if (v[j] > v[j+1]) begin
                            t = v[j]; v[j] = v[j+1]; v[j+1] = t;
                        end
                    end
                end
            end
            bus.i1 = 8'(v[0]);
            bus.i2 = 8'(v[1]);
            bus.i3 = 8'(v[2]);
            bus.i4 = 8'(v[3]);
            bus.in_valid  = ($urandom_range(0, 2) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int n = 0; n < 12; n++) step();
        chk("final_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
